// File: rtl/bdf_prog_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : bdf_prog_sequencer_if
// Description : Bus bundle between the host/config side, the sequencer and
//               the buffer datapath. It carries the code-RAM load port, the
//               run request (length, iteration count, start), the buffer
//               status flags, the push/pop strobes and the status outputs.
//               master : host/datapath side (drives load/start/flags)
//               slave  : sequencer side (drives strobes and status)
// Revision    : 1.0 - initial release
// ============================================================================
interface bdf_prog_sequencer_if #(
    parameter int NUM_BUFFERS = 12,
    parameter int CODE_LENGTH = 128,
    parameter int ITER_WIDTH  = 8
) ();
    localparam int CODE_WIDTH = 2 * NUM_BUFFERS;
    localparam int ADDR_W     = $clog2(CODE_LENGTH);

    // Code RAM load port
    logic                   ld_en;
    logic [ADDR_W-1:0]      ld_addr;
    logic [CODE_WIDTH-1:0]  ld_data;
    // Run request
    logic [ADDR_W:0]        prog_len;
    logic [ITER_WIDTH-1:0]  iter_count;
    logic                   start;
    // Buffer status and strobes
    logic [NUM_BUFFERS-1:0] buf_full;
    logic [NUM_BUFFERS-1:0] buf_empty;
    logic [NUM_BUFFERS-1:0] push;
    logic [NUM_BUFFERS-1:0] pop;
    // Sequencer status
    logic [ADDR_W-1:0]      pc;
    logic [ITER_WIDTH-1:0]  iter;
    logic                   busy;
    logic                   done;
    logic                   err;

    modport master (
        output ld_en, ld_addr, ld_data, prog_len, iter_count, start,
               buf_full, buf_empty,
        input  push, pop, pc, iter, busy, done, err
    );

    modport slave (
        input  ld_en, ld_addr, ld_data, prog_len, iter_count, start,
               buf_full, buf_empty,
        output push, pop, pc, iter, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/bdf_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bdf_prog_sequencer
// Description : Run-time programmable microcode sequencer. A program loaded
//               into the internal code RAM is executed prog_len words per
//               iteration for iter_count iterations. Each word holds a 2-bit
//               op per buffer (bit0 = push, bit1 = pop); a word issues only
//               when none of its ops conflicts with buf_full/buf_empty.
// Ports       : clk    - rising-edge clock
//               rst_n  - synchronous active-low reset
//               bus    - slave side of bdf_prog_sequencer_if (load port, run
//                        request, buffer flags, push/pop strobes, pc, iter,
//                        busy, done, err)
// Revision    : 1.0 - initial release
// ============================================================================
module bdf_prog_sequencer #(
    parameter int NUM_BUFFERS = 12,
    parameter int CODE_LENGTH = 128,
    parameter int ITER_WIDTH  = 8
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    bdf_prog_sequencer_if.slave  bus
);
    localparam int CODE_WIDTH = 2 * NUM_BUFFERS;
    localparam int ADDR_W     = $clog2(CODE_LENGTH);
    localparam logic [ADDR_W:0] PLEN_MAX = (ADDR_W+1)'(CODE_LENGTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      pc_q, pc_d;
    logic [ITER_WIDTH-1:0]  iter_q, iter_d;
    logic [ADDR_W:0]        prog_len_q, prog_len_d;
    logic [ITER_WIDTH-1:0]  iter_cnt_q, iter_cnt_d;
    logic                   err_q, err_d;

    logic [CODE_WIDTH-1:0]  mem_q [CODE_LENGTH];
    logic [CODE_WIDTH-1:0]  word_q;

    logic                   w_ram_we;
    logic                   w_word_ld;
    logic [ADDR_W-1:0]      w_rd_addr;

    logic [NUM_BUFFERS-1:0] w_push_bit;
    logic [NUM_BUFFERS-1:0] w_pop_bit;
    logic [NUM_BUFFERS-1:0] w_conflict;
    logic                   w_go;
    logic                   w_plen_ok;
    logic                   w_last_word;
    logic                   w_last_iter;
    logic [ADDR_W-1:0]      w_next_pc;
    logic                   w_exec;

    // ------------------------------------------------------------------
    // Per-buffer op decode and conflict detection
    // ------------------------------------------------------------------
    for (genvar b = 0; b < NUM_BUFFERS; b++) begin : g_buf
        assign w_push_bit[b] = word_q[2*b];
        assign w_pop_bit[b]  = word_q[2*b+1];
        assign w_conflict[b] = (w_push_bit[b] & bus.buf_full[b]) |
                               (w_pop_bit[b]  & bus.buf_empty[b]);
    end

    // An all-idle word has no conflicts, so it always issues.
    assign w_go        = ~|w_conflict;
    assign w_exec      = (state_q == S_EXEC);
    assign w_plen_ok   = (bus.prog_len != '0) && (bus.prog_len <= PLEN_MAX);
    assign w_last_word = (pc_q == ADDR_W'(prog_len_q - (ADDR_W+1)'(1)));
    assign w_last_iter = (iter_q == (iter_cnt_q - ITER_WIDTH'(1)));
    assign w_next_pc   = w_last_word ? '0 : (pc_q + ADDR_W'(1));

    // ------------------------------------------------------------------
    // Code RAM with a registered read port. The current word register is
    // only loaded on fetch or on an issued word, so a stall simply holds it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            mem_q[bus.ld_addr] <= bus.ld_data;
        end
        if (w_word_ld) begin
            word_q <= mem_q[w_rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            iter_q     <= '0;
            prog_len_q <= '0;
            iter_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            iter_q     <= iter_d;
            prog_len_q <= prog_len_d;
            iter_cnt_q <= iter_cnt_d;
            err_q      <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        iter_d     = iter_q;
        prog_len_d = prog_len_q;
        iter_cnt_d = iter_cnt_q;
        err_d      = 1'b0;
        w_ram_we   = 1'b0;
        w_word_ld  = 1'b0;
        w_rd_addr  = pc_q;

        case (state_q)
            S_IDLE: begin
                w_ram_we = bus.ld_en;
                if (bus.start) begin
                    if (!w_plen_ok) begin
                        err_d = 1'b1;
                    end else begin
                        prog_len_d = bus.prog_len;
                        iter_cnt_d = bus.iter_count;
                        if (bus.iter_count == '0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_FETCH;
                            pc_d    = '0;
                            iter_d  = '0;
                        end
                    end
                end
            end

            S_FETCH: begin
                err_d     = bus.ld_en;
                w_rd_addr = '0;
                w_word_ld = 1'b1;
                state_d   = S_EXEC;
            end

            S_EXEC: begin
                err_d = bus.ld_en;
                if (w_go) begin
                    if (w_last_word && w_last_iter) begin
                        state_d = S_DONE;
                    end else begin
                        // Fetch the following word now so it issues
                        // next cycle without a bubble, including the wrap.
                        w_rd_addr = w_next_pc;
                        w_word_ld = 1'b1;
                        pc_d      = w_next_pc;
                        if (w_last_word) begin
                            iter_d = iter_q + ITER_WIDTH'(1);
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. Strobes are Mealy on the buffer flags and are gated by
    // rst_n so nothing is issued in a reset cycle.
    // ------------------------------------------------------------------
    assign bus.push = (w_exec && w_go && rst_n) ? w_push_bit : '0;
    assign bus.pop  = (w_exec && w_go && rst_n) ? w_pop_bit  : '0;
    assign bus.pc   = pc_q;
    assign bus.iter = iter_q;
    assign bus.busy = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign bus.done = (state_q == S_DONE);
    assign bus.err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bdf_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bdf_prog_sequencer
// Description : Scoreboard bench for bdf_prog_sequencer. Stimulus queues the
//               hand-computed output events (cycle, push, pop, done, err,
//               pc, iter); a monitor pops and compares whenever the DUT shows
//               any strobe, done or err.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bdf_prog_sequencer;
    localparam int NB = 12;
    localparam int CL = 128;
    localparam int IW = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bdf_prog_sequencer_if #(.NUM_BUFFERS(NB), .CODE_LENGTH(CL), .ITER_WIDTH(IW)) bus ();

    bdf_prog_sequencer #(.NUM_BUFFERS(NB), .CODE_LENGTH(CL), .ITER_WIDTH(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          c;
        logic [11:0] pu;
        logic [11:0] po;
        logic        d;
        logic        e;
        logic [6:0]  pc;
        logic [7:0]  it;
        bit          ck;
    } ev_t;

    ev_t sb[$];
    ev_t m_e;
    bit  m_ok;

    // Monitor: every visible output event must match the next expected one.
    always @(negedge clk) begin
        if ((|bus.push) || (|bus.pop) || bus.done || bus.err) begin
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_event cyc=%0d push=%h pop=%h done=%b err=%b required=no event",
                         cyc, bus.push, bus.pop, bus.done, bus.err);
            end else begin
                m_e  = sb.pop_front();
                m_ok = (cyc == m_e.c) && (bus.push == m_e.pu) && (bus.pop == m_e.po) &&
                       (bus.done == m_e.d) && (bus.err == m_e.e);
                if (m_e.ck)
                    m_ok = m_ok && (bus.pc == m_e.pc) && (bus.iter == m_e.it);
                if (!m_ok) begin
                    errors = errors + 1;
                    $display("FAIL event actual: cyc=%0d push=%h pop=%h done=%b err=%b pc=%0d iter=%0d required: cyc=%0d push=%h pop=%h done=%b err=%b pc=%0d iter=%0d",
                             cyc, bus.push, bus.pop, bus.done, bus.err, bus.pc, bus.iter,
                             m_e.c, m_e.pu, m_e.po, m_e.d, m_e.e, m_e.pc, m_e.it);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic ex(int c, logic [11:0] pu, logic [11:0] po, logic d, logic e,
                      logic [6:0] p, logic [7:0] it, bit ck);
        ev_t v;
        v.c = c; v.pu = pu; v.po = po; v.d = d; v.e = e; v.pc = p; v.it = it; v.ck = ck;
        sb.push_back(v);
    endtask

    task automatic load(int a, logic [23:0] w);
        bus.ld_en   = 1'b1;
        bus.ld_addr = 7'(a);
        bus.ld_data = w;
        tick();
        bus.ld_en   = 1'b0;
    endtask

    // Issues a one-cycle start; returns the start cycle T, leaves at T+1.
    task automatic do_start(int pl, int ic, output int t);
        bus.prog_len   = 8'(pl);
        bus.iter_count = 8'(ic);
        bus.start      = 1'b1;
        t = cyc;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic drain(string nm, int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        chk(nm, sb.size(), 0);
        sb.delete();
        tick();
        tick();
    endtask

    // Ten-word program: per-word expected push/pop vectors.
    logic [11:0] pu10 [10] = '{12'h001, 12'h000, 12'h001, 12'h002, 12'h000,
                               12'h004, 12'h000, 12'h008, 12'h000, 12'h010};
    logic [11:0] po10 [10] = '{12'h000, 12'h001, 12'h001, 12'h000, 12'h002,
                               12'h000, 12'h004, 12'h000, 12'h008, 12'h000};

    initial begin
        int t;
        rst_n          = 1'b0;
        bus.ld_en      = 1'b0;
        bus.ld_addr    = '0;
        bus.ld_data    = '0;
        bus.prog_len   = '0;
        bus.iter_count = '0;
        bus.start      = 1'b0;
        bus.buf_full   = '0;
        bus.buf_empty  = '0;
        tick(); tick(); tick();
        @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_done_err", {bus.done, bus.err}, 0);
        chk("reset_pc_iter", {bus.pc, bus.iter}, 0);
        chk("reset_strobes", {bus.push, bus.pop}, 0);
        tick();
        rst_n = 1'b1;
        tick();

        load(0, 24'h000001);
        load(1, 24'h000002);
        load(2, 24'h000003);

        // Basic run: 3 words x 2 iterations
        do_start(3, 2, t);
        ex(t+2, 12'h001, 12'h000, 0, 0, 0, 0, 1);
        ex(t+3, 12'h000, 12'h001, 0, 0, 1, 0, 1);
        ex(t+4, 12'h001, 12'h001, 0, 0, 2, 0, 1);
        ex(t+5, 12'h001, 12'h000, 0, 0, 0, 1, 1);
        ex(t+6, 12'h000, 12'h001, 0, 0, 1, 1, 1);
        ex(t+7, 12'h001, 12'h001, 0, 0, 2, 1, 1);
        ex(t+8, 12'h000, 12'h000, 1, 0, 2, 1, 1);
        @(negedge clk);
        chk("fetch_busy", 32'(bus.busy), 1);
        wait_until(t+8);
        @(negedge clk);
        chk("done_busy_low", 32'(bus.busy), 0);
        chk("end_iter", 32'(bus.iter), 1);
        drain("drain_basic", 20);

        // Stall: buf_empty[0] high for cycles T+3..T+6
        do_start(3, 2, t);
        ex(t+2,  12'h001, 12'h000, 0, 0, 0, 0, 1);
        ex(t+7,  12'h000, 12'h001, 0, 0, 1, 0, 1);
        ex(t+8,  12'h001, 12'h001, 0, 0, 2, 0, 1);
        ex(t+9,  12'h001, 12'h000, 0, 0, 0, 1, 1);
        ex(t+10, 12'h000, 12'h001, 0, 0, 1, 1, 1);
        ex(t+11, 12'h001, 12'h001, 0, 0, 2, 1, 1);
        ex(t+12, 12'h000, 12'h000, 1, 0, 2, 1, 1);
        wait_until(t+3);
        bus.buf_empty = 12'h001;
        wait_until(t+4);
        @(negedge clk);
        chk("stall_pc", 32'(bus.pc), 1);
        wait_until(t+7);
        bus.buf_empty = '0;
        drain("drain_stall", 30);

        // Invalid lengths
        do_start(0, 1, t);
        ex(t+1, 12'h000, 12'h000, 0, 1, 2, 1, 1);
        @(negedge clk);
        chk("err0_busy", 32'(bus.busy), 0);
        tick();
        do_start(CL+1, 1, t);
        ex(t+1, 12'h000, 12'h000, 0, 1, 2, 1, 1);
        @(negedge clk);
        chk("err129_busy", 32'(bus.busy), 0);
        drain("drain_err", 10);

        // Zero iterations
        do_start(3, 0, t);
        ex(t+1, 12'h000, 12'h000, 1, 0, 0, 0, 0);
        @(negedge clk);
        chk("iter0_busy", 32'(bus.busy), 0);
        drain("drain_iter0", 10);

        // Load attempt during a run
        do_start(3, 1, t);
        ex(t+2, 12'h001, 12'h000, 0, 0, 0, 0, 1);
        ex(t+3, 12'h000, 12'h001, 0, 0, 1, 0, 1);
        ex(t+4, 12'h001, 12'h001, 0, 1, 2, 0, 1);
        ex(t+5, 12'h000, 12'h000, 1, 0, 2, 0, 1);
        wait_until(t+3);
        bus.ld_en   = 1'b1;
        bus.ld_addr = 7'd1;
        bus.ld_data = 24'hFFFFFF;
        tick();
        bus.ld_en   = 1'b0;
        drain("drain_ldrun", 20);

        // Reset mid-run, then rerun the intact program
        load(3, 24'h000004);
        load(4, 24'h000008);
        load(5, 24'h000010);
        load(6, 24'h000020);
        load(7, 24'h000040);
        load(8, 24'h000080);
        load(9, 24'h000100);
        do_start(10, 1, t);
        ex(t+2, 12'h001, 12'h000, 0, 0, 0, 0, 1);
        ex(t+3, 12'h000, 12'h001, 0, 0, 1, 0, 1);
        wait_until(t+4);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_push", 32'(bus.push), 0);
        chk("rst_pop", 32'(bus.pop), 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 0);
        chk("post_rst_pc_iter", {bus.pc, bus.iter}, 0);
        drain("drain_rst", 10);

        do_start(10, 1, t);
        for (int i = 0; i < 10; i++)
            ex(t+2+i, pu10[i], po10[i], 0, 0, 7'(i), 0, 1);
        ex(t+12, 12'h000, 12'h000, 1, 0, 9, 0, 1);
        drain("drain_rerun", 30);

        // Full-length program, maximum iterations, all-idle words
        for (int i = 0; i < CL; i++) load(i, 24'h000000);
        do_start(CL, 255, t);
        ex(t+2+CL*255, 12'h000, 12'h000, 1, 0, 127, 254, 1);
        wait_until(t+2+127);
        @(negedge clk);
        chk("wrap_pc127", 32'(bus.pc), 127);
        tick();
        @(negedge clk);
        chk("wrap_pc0_iter1", {bus.pc, bus.iter}, {7'd0, 8'd1});
        drain("drain_long", 33000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
